// File: rtl/dmem_pkg.sv
// dmem_pkg: shared response type and constants for the pipelined data memory
package dmem_pkg;
  localparam int LATENCY_MAX = 4;
  localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;
endpackage

// File: rtl/dmem_rsp_fifo.sv
// dmem_rsp_fifo: show-ahead response FIFO; head entry is visible whenever o_valid is high
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = dmem_rsp_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_valid,
  output T     o_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (i_push) wr_ptr <= nxt(wr_ptr);
      if (i_pop) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push) mem[wr_ptr] <= i_data;
  assign o_valid = cnt != '0;
  assign o_data  = mem[rd_ptr];
endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined data memory with valid/ready requests and in-order responses.
// Define DMEM_STALL_INJECT_EN to add LFSR-driven request back-pressure.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int DEPTH_WORDS     = 2048,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [31:0]         i_req_addr,
  input  logic                i_req_we,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_wmask,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err
);
  localparam int OFF = $clog2(DATA_W / 8);
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;
  logic [DATA_W-1:0] q [DEPTH_WORDS];
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx;
  logic [LATENCY-1:0] pipe_v;
  rsp_t pipe_d [LATENCY];
  rsp_t rsp_in, head;
  logic acc, in_range, rsp_hs, stall_ok;
  assign acc      = i_req_valid & o_req_ready;
  assign in_range = (i_req_addr >> OFF) < 32'(DEPTH_WORDS);
  assign idx      = AW'(i_req_addr >> OFF);
  assign rsp_hs   = o_rsp_valid & i_rsp_ready;
  always_comb begin
    rsp_in.rdata = (!i_req_we && in_range) ? q[idx] : '0;
    rsp_in.err   = !in_range;
    cnt_n = (acc && !rsp_hs) ? cnt + 1'b1 : (!acc && rsp_hs) ? cnt - 1'b1 : cnt;
  end
`ifdef DMEM_STALL_INJECT_EN
  logic [15:0] lfsr, lfsr_n;
  assign lfsr_n   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall_ok = lfsr_n[1:0] != 2'b00;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) lfsr <= DMEM_LFSR_SEED;
    else lfsr <= lfsr_n;
`else
  assign stall_ok = 1'b1;
`endif
  // ready is registered from the next count so the in-flight total never exceeds the FIFO depth
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt         <= '0;
      o_req_ready <= 1'b1;
      pipe_v      <= '0;
      for (int k = 0; k < LATENCY; k++) pipe_d[k] <= '0;
    end else begin
      cnt         <= cnt_n;
      o_req_ready <= (cnt_n < CW'(MAX_OUTSTANDING)) && stall_ok;
      pipe_v[0]   <= acc;
      pipe_d[0]   <= rsp_in;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  always_ff @(posedge i_clk)
    if (acc && i_req_we && in_range)
      for (int b = 0; b < DATA_W / 8; b++)
        if (i_req_wmask[b]) q[idx][8*b+:8] <= i_req_wdata[8*b+:8];
  dmem_rsp_fifo #(.DEPTH(MAX_OUTSTANDING), .T(rsp_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (pipe_v[LATENCY-1]),
    .i_data  (pipe_d[LATENCY-1]),
    .i_pop   (rsp_hs),
    .o_valid (o_rsp_valid),
    .o_data  (head)
  );
  assign o_rsp_rdata = o_rsp_valid ? head.rdata : '0;
  assign o_rsp_err   = o_rsp_valid & head.err;
endmodule
